// File: rtl/carfield_region_map_pkg.sv
// Shared word offsets, control bit positions and the region entry type
// for the runtime-programmable Carfield address region table.
package carfield_region_map_pkg;

  localparam int unsigned MaxAddrWidth = 64;

  localparam logic [1:0] RegBaseLo = 2'd0;
  localparam logic [1:0] RegBaseHi = 2'd1;
  localparam logic [1:0] RegSizeLo = 2'd2;
  localparam logic [1:0] RegSizeHi = 2'd3;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegEnable = 2'd1;
  localparam logic [1:0] RegStatus = 2'd2;

  localparam int unsigned CtrlCommit    = 0;
  localparam int unsigned CtrlLock      = 1;
  localparam int unsigned StatusPending = 0;
  localparam int unsigned StatusLocked  = 1;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] size;
  } region_t;

  function automatic logic [MaxAddrWidth-1:0] addr_mask(
    input int unsigned aw
  );
    if (aw >= MaxAddrWidth) return '1;
    return (64'd1 << aw) - 64'd1;
  endfunction

endpackage

// File: rtl/carfield_region_match.sv
// Combinational comparator array: per-region match vector,
// lowest-index winner and multiple-match flag.
module carfield_region_match #(
  parameter int NumRegions = 16,
  parameter int AddrWidth  = 64,
  parameter int IdxWidth   = 4
) (
  input  logic [AddrWidth-1:0]                  addr,
  input  logic [NumRegions-1:0][AddrWidth-1:0]  base,
  input  logic [NumRegions-1:0][AddrWidth-1:0]  size,
  input  logic [NumRegions-1:0]                 en,
  output logic [NumRegions-1:0]                 match,
  output logic [IdxWidth-1:0]                   idx,
  output logic                                  multi
);

  logic seen;

  // The offset is taken at AddrWidth, so a region cannot wrap past the top.
  always_comb begin
    match = '0;
    for (int r = 0; r < NumRegions; r++) begin
      match[r] = en[r]
              && (size[r] != '0)
              && (addr >= base[r])
              && ((addr - base[r]) < size[r]);
    end
  end

  always_comb begin
    seen  = 1'b0;
    idx   = '0;
    multi = 1'b0;
    for (int r = 0; r < NumRegions; r++) begin
      if (match[r]) begin
        if (seen) begin
          multi = 1'b1;
        end else begin
          seen = 1'b1;
          idx  = IdxWidth'(r);
        end
      end
    end
  end

endmodule

// File: rtl/carfield_region_map.sv
// Programmable region table: shadow/active copies, atomic commit,
// sticky lock and a single-stage registered lookup pipeline.
module carfield_region_map
  import carfield_region_map_pkg::*;
#(
  parameter int NumRegions = 16,
  parameter int AddrWidth  = 64,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultBase = '0,
  parameter logic [NumRegions-1:0][AddrWidth-1:0] DefaultSize = '0,
  parameter logic [NumRegions-1:0] DefaultEnable = '0,
  localparam int IdxWidth = (NumRegions > 1) ? $clog2(NumRegions) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_req_valid_i,
  output logic                 cfg_req_ready_o,
  input  logic                 cfg_req_write_i,
  input  logic [7:0]           cfg_req_addr_i,
  input  logic [31:0]          cfg_req_wdata_i,
  output logic                 cfg_rsp_valid_o,
  output logic [31:0]          cfg_rsp_rdata_o,
  output logic                 cfg_rsp_error_o,
  input  logic                 lkp_valid_i,
  output logic                 lkp_ready_o,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  input  logic                 lkp_ready_i,
  output logic                 lkp_hit_o,
  output logic [IdxWidth-1:0]  lkp_idx_o,
  output logic                 lkp_multi_o,
  output logic                 locked_o,
  output logic                 commit_pending_o
);

  localparam logic [63:0] Mask = addr_mask(AddrWidth);

  region_t [NumRegions-1:0] defaults;
  region_t [NumRegions-1:0] shadow_q, shadow_d;
  region_t [NumRegions-1:0] active_q, active_d;
  logic [NumRegions-1:0]    en_sh_q, en_sh_d;
  logic [NumRegions-1:0]    en_act_q, en_act_d;
  logic                     pending_q, pending_d;
  logic                     locked_q, locked_d;

  logic                     rsp_valid_q;
  logic [31:0]              rsp_rdata_q, rdata_d;
  logic                     rsp_error_q, error_d;

  logic                     lkp_valid_q;
  logic                     hit_q, multi_q;
  logic [IdxWidth-1:0]      idx_q;

  logic [5:0]               sel;
  logic [1:0]               word;
  logic                     is_region, is_glob, bad_idx;
  logic                     commit_fire, lkp_accept;
  region_t                  cur;
  logic [31:0]              rd_word;

  logic [NumRegions-1:0][AddrWidth-1:0] base_act, size_act;
  logic [NumRegions-1:0]    match_vec;
  logic [IdxWidth-1:0]      match_idx;
  logic                     match_multi;

  always_comb begin
    for (int r = 0; r < NumRegions; r++) begin
      defaults[r].base = 64'(DefaultBase[r]);
      defaults[r].size = 64'(DefaultSize[r]);
    end
  end

  assign sel       = cfg_req_addr_i[7:2];
  assign word      = cfg_req_addr_i[1:0];
  assign is_region = sel < 6'(NumRegions);
  assign is_glob   = sel == 6'(NumRegions);
  assign bad_idx   = !is_region && !(is_glob && word != 2'd3);

  // The commit waits until no lookup result is being held downstream.
  assign commit_fire = pending_q && (!lkp_valid_q || lkp_ready_i);
  assign lkp_ready_o = !pending_q && (!lkp_valid_q || lkp_ready_i);
  assign lkp_accept  = lkp_valid_i && lkp_ready_o;

  always_comb begin
    cur = '0;
    for (int r = 0; r < NumRegions; r++) begin
      if (sel == 6'(r)) cur = shadow_q[r];
    end
    rd_word = '0;
    if (is_region) begin
      case (word)
        RegBaseLo: rd_word = cur.base[31:0];
        RegBaseHi: rd_word = cur.base[63:32];
        RegSizeLo: rd_word = cur.size[31:0];
        default:   rd_word = cur.size[63:32];
      endcase
    end else begin
      case (word)
        RegCtrl:   rd_word[CtrlLock] = locked_q;
        RegEnable: rd_word = 32'(en_sh_q);
        RegStatus: begin
          rd_word[StatusPending] = pending_q;
          rd_word[StatusLocked]  = locked_q;
        end
        default:   rd_word = '0;
      endcase
    end
  end

  always_comb begin
    shadow_d  = shadow_q;
    en_sh_d   = en_sh_q;
    active_d  = active_q;
    en_act_d  = en_act_q;
    pending_d = pending_q;
    locked_d  = locked_q;
    rdata_d   = '0;
    error_d   = 1'b0;
    if (commit_fire) begin
      active_d  = shadow_q;
      en_act_d  = en_sh_q;
      pending_d = 1'b0;
    end
    if (cfg_req_valid_i) begin
      if (bad_idx) begin
        error_d = 1'b1;
      end else if (!cfg_req_write_i) begin
        rdata_d = rd_word;
      end else if (locked_q || (is_glob && word == RegStatus)) begin
        error_d = 1'b1;
      end else if (is_glob) begin
        if (word == RegEnable) begin
          en_sh_d = cfg_req_wdata_i[NumRegions-1:0];
        end else begin
          // Commit is armed before the lock lands, so both apply.
          if (cfg_req_wdata_i[CtrlCommit]) pending_d = 1'b1;
          if (cfg_req_wdata_i[CtrlLock])   locked_d  = 1'b1;
        end
      end else begin
        for (int r = 0; r < NumRegions; r++) begin
          if (sel == 6'(r)) begin
            case (word)
              RegBaseLo: shadow_d[r].base =
                {shadow_q[r].base[63:32], cfg_req_wdata_i} & Mask;
              RegBaseHi: shadow_d[r].base =
                {cfg_req_wdata_i, shadow_q[r].base[31:0]} & Mask;
              RegSizeLo: shadow_d[r].size =
                {shadow_q[r].size[63:32], cfg_req_wdata_i} & Mask;
              default:   shadow_d[r].size =
                {cfg_req_wdata_i, shadow_q[r].size[31:0]} & Mask;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q    <= defaults;
      active_q    <= defaults;
      en_sh_q     <= DefaultEnable;
      en_act_q    <= DefaultEnable;
      pending_q   <= 1'b0;
      locked_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      en_sh_q     <= en_sh_d;
      en_act_q    <= en_act_d;
      pending_q   <= pending_d;
      locked_q    <= locked_d;
      rsp_valid_q <= cfg_req_valid_i;
      rsp_rdata_q <= rdata_d;
      rsp_error_q <= error_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NumRegions; r++) begin
      base_act[r] = active_q[r].base[AddrWidth-1:0];
      size_act[r] = active_q[r].size[AddrWidth-1:0];
    end
  end

  carfield_region_match #(
    .NumRegions (NumRegions),
    .AddrWidth  (AddrWidth),
    .IdxWidth   (IdxWidth)
  ) u_match (
    .addr  (lkp_addr_i),
    .base  (base_act),
    .size  (size_act),
    .en    (en_act_q),
    .match (match_vec),
    .idx   (match_idx),
    .multi (match_multi)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lkp_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      multi_q     <= 1'b0;
    end else if (lkp_accept) begin
      lkp_valid_q <= 1'b1;
      hit_q       <= |match_vec;
      idx_q       <= match_idx;
      multi_q     <= match_multi;
    end else if (lkp_ready_i) begin
      lkp_valid_q <= 1'b0;
    end
  end

  assign cfg_req_ready_o  = 1'b1;
  assign cfg_rsp_valid_o  = rsp_valid_q;
  assign cfg_rsp_rdata_o  = rsp_rdata_q;
  assign cfg_rsp_error_o  = rsp_error_q;
  assign lkp_valid_o      = lkp_valid_q;
  assign lkp_hit_o        = hit_q;
  assign lkp_idx_o        = idx_q;
  assign lkp_multi_o      = multi_q;
  assign locked_o         = locked_q;
  assign commit_pending_o = pending_q;

endmodule

// File: doc/carfield_region_map.md
# carfield_region_map

Runtime-programmable address region table that replaces the fixed, elaboration-time region map for Carfield's AXI/RegBus subsystems. It holds `NumRegions` base/size/enable entries behind a 32-bit configuration port, with shadow registers and an atomic commit. It also includes a lock bit that freezes the map until reset. A pipelined lookup port returns the matching region index for an address, so crossbar rule generation and access filtering can follow the programmed map.

## Interface
- `NumRegions`, 16: table entries, 1..32.
- `AddrWidth`, 64: lookup/base/size width, 33..64.
- `DefaultBase`, all 0: `logic [NumRegions-1:0][AddrWidth-1:0]`, reset base per entry.
- `DefaultSize`, all 0: same shape, reset size per entry.
- `DefaultEnable`, 0: `logic [NumRegions-1:0]`, reset enable bits.
- `clk_i  in  1  clock`
- `rst_i  in  1  reset, synchronous, active-high`
- `cfg_req_valid_i  in  1  config request`
- `cfg_req_ready_o  out  1  config request accepted; constant 1`
- `cfg_req_write_i  in  1  1 = write, 0 = read`
- `cfg_req_addr_i  in  8  word index`
- `cfg_req_wdata_i  in  32  write data`
- `cfg_rsp_valid_o  out  1  one-cycle response pulse`
- `cfg_rsp_rdata_o  out  32  read data; 0 on error or write`
- `cfg_rsp_error_o  out  1  bad index, or write while locked`
- `lkp_valid_i / lkp_ready_o  in/out  1  lookup request handshake`
- `lkp_addr_i  in  AddrWidth  lookup address`
- `lkp_valid_o / lkp_ready_i  out/in  1  lookup result handshake`
- `lkp_hit_o  out  1  some enabled region matched`
- `lkp_idx_o  out  $clog2(NumRegions) (min 1)  matched index; 0 on miss`
- `lkp_multi_o  out  1  more than one region matched`
- `locked_o  out  1  map frozen`
- `commit_pending_o  out  1  commit requested, not yet applied`

## Operation
- **Word map, region r:**
  - 4r: BASE_LO.
  - 4r+1: BASE_HI (bits above `AddrWidth` read 0 and ignore writes).
  - 4r+2: SIZE_LO.
  - 4r+3: SIZE_HI.
- **Word map, global:**
  - 4N = CTRL: bit0 COMMIT, write-1, reads 0; bit1 LOCK, write-1-sticky.
  - 4N+1 = ENABLE, bit r = region r.
  - 4N+2 = STATUS: bit0 commit pending, bit1 locked; read-only, writes return error.
- Any other index returns error.
- Config writes update only the shadow copy. Reads return the shadow copy.
- **Commit:**
  - Writing COMMIT=1 sets the pending flag.
  - While pending, `lkp_ready_o=0`.
  - Once no lookup result is held (`lkp_valid_o=0`, or the handshake completes this cycle), all shadow entries and ENABLE copy to active in one cycle and the pending flag clears.
  - A COMMIT while already pending is a no-op.
- **Lock:**
  - Writing LOCK=1 sets `locked_o`. Only `rst_i` clears it.
  - While locked, every write (including CTRL) has no effect and returns `error=1`. Reads still work.
  - A write setting COMMIT and LOCK together commits first, then locks.
- **Match, region r:** `en[r] && size[r]!=0 && addr>=base[r] && (addr-base[r])<size[r]`.
  - Compute the subtraction at `AddrWidth`. This gives no wrap at the top of the address space.
  - The lowest matching index wins. `lkp_multi_o` = popcount of matches > 1.
- Lookups use only the active copy. The shadow never affects lookups.

## Timing
- **Reset values:**
  - Shadow and active tables = `Default*`.
  - Pending, lock, `cfg_rsp_valid_o`, `lkp_valid_o` = 0.
  - All data outputs = 0.
- **Config:** request accepted every cycle it is valid. Response appears exactly one cycle later. No response backpressure.
- A write in cycle t is visible to a read accepted in cycle t+1.
- A COMMIT accepted in cycle t, with the lookup output empty, makes active = shadow in cycle t+1. `commit_pending_o` is high for that one cycle.
- **Lookup:** single registered stage, latency 1.
  - `lkp_ready_o = !commit_pending && (!lkp_valid_o || lkp_ready_i)`.
  - Full throughput: one result per cycle under continuous ready.
  - Result registers hold stable while `lkp_valid_o && !lkp_ready_i`.
- **Simultaneous events:**
  - A config write and a lookup in the same cycle: the lookup uses the pre-commit active table.
  - A commit applied in the same cycle as a result handshake: permitted.
- `rst_i` mid-operation: drops any pending commit and in-flight result. The table returns to defaults next cycle.

## Structure
- Package `carfield_region_map_pkg` holds:
  - Word offset localparams: `RegBaseLo`, `RegBaseHi`, `RegSizeLo`, `RegSizeHi`, `RegCtrl`, `RegEnable`, `RegStatus`.
  - CTRL/STATUS bit positions.
  - Parametrised `region_t` (base, size).
- Sub-module `carfield_region_match`: combinational comparator array producing the match vector, winning index and multi flag. The top module holds the registers, commit/lock FSM and pipeline stage.

## Test plan
- **Reset defaults and upper boundary.** Setup: `DefaultBase[0]='h78000000`, `DefaultSize[0]='h200000`, `DefaultEnable=1`.
  - Lookup `'h781FFFFF` → next cycle hit=1, idx=0.
  - Lookup `'h78200000` → hit=0, idx=0.
- **Shadow vs active.**
  - Write region 1 base `'h78200000`, size `'h200000`, ENABLE=`'b11`. Lookup `'h78200010` → miss.
  - COMMIT, then the same lookup → hit, idx=1.
- **Commit stall.**
  - Hold `lkp_ready_i=0` with a result pending, then write COMMIT → `lkp_ready_o=0`, `commit_pending_o=1`, result stable.
  - Release `lkp_ready_i` → commit applies that cycle; `lkp_ready_o` returns high next cycle.
- **Overlap.**
  - Regions 2 and 5 both cover `'h50000000`, commit → lookup gives idx=2, multi=1.
- **Lock.**
  - Write CTRL=`'b11` → commit applied, `locked_o=1`.
  - Later write BASE_LO r0 → error=1, readback unchanged.
  - Write STATUS → error=1.
  - Write index 4N+3 → error=1.
- **Reset mid-operation.** Reset with commit pending and a result held → all outputs 0, table = defaults, `locked_o=0`.
